// File: rtl/ext_mem_port_ctrl.sv
`timescale 1ns/1ps
// ext_mem_port_ctrl: boots an ElectronNest fabric from a single-port synchronous
// SRAM, then shares that SRAM port between load and store requests round-robin.
//
// Handshake summary:
//   O_Ld_FTk.v=1 offers a token. It is taken when I_Ld_BTk.n=0 in the same cycle.
//   With n=1 the token repeats unchanged on later cycles until a cycle with n=0.
//   O_Ld_Gnt=1 means the load request was accepted in this cycle. The token for
//   that load appears on the next cycle.
//   O_St_BTk.n=0 means the store was written in this cycle. O_St_BTk.n=1 means
//   it was refused and must be presented again.
//
// BOOT_LEAD and BOOT_WORDS must both be at least 1. DEPTH_MEM must be a power
// of two and smaller than 2**WIDTH_EXADDR.

package ext_mem_port_ctrl_pkg;
    localparam int FTK_D_W = 32;
    localparam int FTK_I_W = 32;

    typedef struct packed {
        logic               v;
        logic               a;
        logic               r;
        logic               c;
        logic [FTK_D_W-1:0] d;
        logic [FTK_I_W-1:0] i;
    } FTk_t;

    // n: nack. t: reserved, driven 0.
    typedef struct packed {
        logic n;
        logic t;
    } BTk_t;
endpackage

module ext_mem_port_ctrl
    import ext_mem_port_ctrl_pkg::*;
#(
    parameter int WIDTH_DATA   = FTK_D_W,
    parameter int WIDTH_EXADDR = FTK_I_W,
    parameter int DEPTH_MEM    = 1024,
    parameter int BOOT_LEAD    = 3,
    parameter int BOOT_WORDS   = 5,
    parameter int EXTEND_MEM   = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    input  logic                    I_Ld_Req,
    input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
    output FTk_t                    O_Ld_FTk,
    input  BTk_t                    I_Ld_BTk,
    output logic                    O_Ld_Gnt,
    input  logic                    I_St_Req,
    input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
    input  FTk_t                    I_St_FTk,
    output BTk_t                    O_St_BTk,
    output logic                    O_Mem_En,
    output logic                    O_Mem_We,
    output logic [WIDTH_EXADDR-1:0] O_Mem_Addr,
    output logic [WIDTH_DATA-1:0]   O_Mem_WData,
    input  logic [WIDTH_DATA-1:0]   I_Mem_RData,
    output logic                    O_Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_PROG = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    typedef enum logic {
        RR_LD = 1'b0,
        RR_ST = 1'b1
    } rr_e;

    localparam int AW      = $clog2(DEPTH_MEM);
    localparam int CNT_MAX = (BOOT_LEAD > BOOT_WORDS) ? BOOT_LEAD : BOOT_WORDS;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]        LEAD_LAST = CNT_W'(BOOT_LEAD - 1);
    localparam logic [CNT_W-1:0]        PROG_LAST = CNT_W'(BOOT_WORDS - 1);
    localparam logic [WIDTH_EXADDR-1:0] ADDR_MASK =
        {{(WIDTH_EXADDR - AW){1'b0}}, {AW{1'b1}}};

    // Registered state
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    rr_e                rr_q, rr_d;
    logic               rd_pend_q, rd_pend_d;
    logic [FTK_I_W-1:0] rd_i_q, rd_i_d;
    logic               hold_q, hold_d;
    FTk_t               hold_tok_q, hold_tok_d;

    // Combinational signals
    FTk_t                    tok;
    logic                    tok_acc;
    logic                    ld_hold;
    logic                    st_elig;
    logic                    ld_elig;
    logic                    mem_en;
    logic                    mem_we;
    logic [WIDTH_EXADDR-1:0] mem_addr_raw;
    logic [WIDTH_DATA-1:0]   mem_wdata;
    logic                    ld_gnt;
    logic                    st_gnt;
    logic                    unused_inputs;

    assign unused_inputs = ^{I_St_FTk.a, I_St_FTk.r, I_St_FTk.c, I_St_FTk.i, I_Ld_BTk.t};

    // Token source: a held token takes priority, then SRAM read data, then a lead word.
    always_comb begin
        tok        = '0;
        if (hold_q) begin
            tok = hold_tok_q;
        end else if (rd_pend_q) begin
            tok.v = 1'b1;
            tok.d = FTK_D_W'(I_Mem_RData);
            tok.i = rd_i_q;
        end else if (state_q == ST_LEAD) begin
            tok.v = 1'b1;
            tok.a = (cnt_q == '0);
        end
        tok_acc    = tok.v & ~I_Ld_BTk.n;
        ld_hold    = tok.v & I_Ld_BTk.n;
        hold_d     = ld_hold;
        hold_tok_d = ld_hold ? tok : hold_tok_q;
    end

    // Next-state and SRAM port control for boot sequencing and run-time arbitration.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        rd_pend_d    = 1'b0;
        rd_i_d       = '0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr_raw = '0;
        mem_wdata    = '0;
        ld_gnt       = 1'b0;
        st_gnt       = 1'b0;
        st_elig      = I_St_Req & I_St_FTk.v;
        ld_elig      = I_Ld_Req & ~ld_hold;

        case (state_q)
            ST_IDLE: begin
                if (I_Boot) begin
                    state_d = ST_LEAD;
                    cnt_d   = '0;
                end
            end

            // The last lead word reads mem[0], so program word 0 follows without a gap.
            ST_LEAD: begin
                if (tok_acc) begin
                    if (cnt_q == LEAD_LAST) begin
                        mem_en       = 1'b1;
                        mem_addr_raw = '0;
                        rd_pend_d    = 1'b1;
                        state_d      = ST_PROG;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Word cnt_q is on the token. The next word is read only when this one is taken.
            ST_PROG: begin
                if (tok_acc) begin
                    if (cnt_q == PROG_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        mem_en       = 1'b1;
                        mem_addr_raw = WIDTH_EXADDR'(cnt_q) + WIDTH_EXADDR'(1);
                        rd_pend_d    = 1'b1;
                        cnt_d        = cnt_q + 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (st_elig && (!ld_elig || rr_q == RR_ST)) begin
                    st_gnt       = 1'b1;
                    mem_en       = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_raw = I_St_Addr;
                    mem_wdata    = WIDTH_DATA'(I_St_FTk.d);
                end else if (ld_elig) begin
                    ld_gnt       = 1'b1;
                    mem_en       = 1'b1;
                    mem_addr_raw = I_Ld_Addr;
                    rd_pend_d    = 1'b1;
                    rd_i_d       = (EXTEND_MEM != 0) ? FTK_I_W'(I_Ld_Addr) : '0;
                end
                if (st_elig && ld_elig) begin
                    rr_d = (rr_q == RR_LD) ? RR_ST : RR_LD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. A reset drops any read in flight, so no token follows it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_q       <= RR_LD;
            rd_pend_q  <= 1'b0;
            rd_i_q     <= '0;
            hold_q     <= 1'b0;
            hold_tok_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            rd_pend_q  <= rd_pend_d;
            rd_i_q     <= rd_i_d;
            hold_q     <= hold_d;
            hold_tok_q <= hold_tok_d;
        end
    end

    assign O_Ld_FTk    = tok;
    assign O_Ld_Gnt    = ld_gnt;
    assign O_St_BTk.n  = I_St_Req & ~st_gnt;
    assign O_St_BTk.t  = 1'b0;
    assign O_Mem_En    = mem_en;
    assign O_Mem_We    = mem_we;
    assign O_Mem_Addr  = mem_addr_raw & ADDR_MASK;
    assign O_Mem_WData = mem_wdata;
    assign O_Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ext_mem_port_ctrl.sv
`timescale 1ns/1ps
// Bench for ext_mem_port_ctrl. Expected load/boot tokens are queued when the
// stimulus is issued. A negedge monitor compares every valid O_Ld_FTk with the
// head of the queue and pops the entry when the token is taken.
module tb_ext_mem_port_ctrl;
  import ext_mem_port_ctrl_pkg::*;

  localparam int W = $bits(FTk_t);

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        I_Boot;
  logic        I_Ld_Req;
  logic [31:0] I_Ld_Addr;
  FTk_t        O_Ld_FTk;
  BTk_t        I_Ld_BTk;
  logic        O_Ld_Gnt;
  logic        I_St_Req;
  logic [31:0] I_St_Addr;
  FTk_t        I_St_FTk;
  BTk_t        O_St_BTk;
  logic        O_Mem_En;
  logic        O_Mem_We;
  logic [31:0] O_Mem_Addr;
  logic [31:0] O_Mem_WData;
  logic [31:0] I_Mem_RData;
  logic        O_Busy;

  ext_mem_port_ctrl dut (
    .clock(clock), .reset(reset), .I_Boot(I_Boot),
    .I_Ld_Req(I_Ld_Req), .I_Ld_Addr(I_Ld_Addr), .O_Ld_FTk(O_Ld_FTk),
    .I_Ld_BTk(I_Ld_BTk), .O_Ld_Gnt(O_Ld_Gnt),
    .I_St_Req(I_St_Req), .I_St_Addr(I_St_Addr), .I_St_FTk(I_St_FTk),
    .O_St_BTk(O_St_BTk), .O_Mem_En(O_Mem_En), .O_Mem_We(O_Mem_We),
    .O_Mem_Addr(O_Mem_Addr), .O_Mem_WData(O_Mem_WData),
    .I_Mem_RData(I_Mem_RData), .O_Busy(O_Busy)
  );

  // SRAM model: read data appears one cycle after a read access
  logic [31:0] mem [0:1023];
  always @(posedge clock) begin
    if (O_Mem_En) begin
      if (O_Mem_We) mem[O_Mem_Addr[9:0]] <= O_Mem_WData;
      else          I_Mem_RData <= mem[O_Mem_Addr[9:0]];
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int vcyc  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] tk(input logic a, input logic [31:0] d);
    FTk_t t;
    t   = '0;
    t.v = 1'b1;
    t.a = a;
    t.d = d;
    return t;
  endfunction

  // monitor
  always @(negedge clock) begin
    if (O_Ld_FTk.v === 1'b1) begin
      vcyc++;
      if (exp_q.size() == 0) begin
        chk("unexpected_token", O_Ld_FTk, '0);
      end else begin
        chk("ld_token", O_Ld_FTk, exp_q[0]);
        if (!I_Ld_BTk.n) void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    I_Boot    = 1'b0;
    I_Ld_Req  = 1'b0;
    I_Ld_Addr = '0;
    I_Ld_BTk  = '0;
    I_St_Req  = 1'b0;
    I_St_Addr = '0;
    I_St_FTk  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic boot_push();
    exp_q.push_back(tk(1'b1, 32'd0));
    exp_q.push_back(tk(1'b0, 32'd0));
    exp_q.push_back(tk(1'b0, 32'd0));
    for (int k = 0; k < 5; k++) exp_q.push_back(tk(1'b0, 32'd11 + 32'(k)));
  endtask

  task automatic pulse_boot();
    I_Boot = 1'b1;
    tick();
    I_Boot = 1'b0;
  endtask

  task automatic wait_boot_done(input string name, input int exp_vcyc);
    repeat (12) tick();
    @(negedge clock);
    chk({name, "_queue_empty"}, W'(exp_q.size()), '0);
    chk({name, "_valid_cycles"}, W'(vcyc), W'(exp_vcyc));
    chk({name, "_busy"}, W'(O_Busy), W'(1));
    chk({name, "_v_after"}, W'(O_Ld_FTk.v), '0);
    tick();
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = '0;
    for (int k = 0; k < 5; k++) mem[k] = 32'd11 + 32'(k);
    mem[7] = 32'hDEAD;
    mem[9] = 32'h99;
    I_Mem_RData = '0;
    clear_inputs();
    reset = 1'b0;

    // reset state
    tick();
    tick();
    @(negedge clock);
    chk("rst_busy", W'(O_Busy), '0);
    chk("rst_ld_ftk", O_Ld_FTk, '0);
    chk("rst_st_btk", W'(O_St_BTk), '0);
    chk("rst_mem_en", W'(O_Mem_En), '0);
    chk("rst_mem_we", W'(O_Mem_We), '0);
    chk("rst_ld_gnt", W'(O_Ld_Gnt), '0);
    tick();
    reset = 1'b1;

    // requests in IDLE are refused
    I_St_Req = 1'b1; I_St_FTk.v = 1'b1; I_St_FTk.d = 32'h1; I_St_Addr = 32'd3;
    I_Ld_Req = 1'b1; I_Ld_Addr = 32'd7;
    @(negedge clock);
    chk("idle_st_n", W'(O_St_BTk.n), W'(1));
    chk("idle_mem_en", W'(O_Mem_En), '0);
    chk("idle_ld_gnt", W'(O_Ld_Gnt), '0);
    tick();
    clear_inputs();
    tick();

    // plain boot
    boot_push();
    vcyc = 0;
    pulse_boot();
    wait_boot_done("boot1", 8);

    // boot with a two-cycle nack on program word 2
    do_reset();
    boot_push();
    vcyc = 0;
    pulse_boot();
    repeat (5) tick();
    I_Ld_BTk.n = 1'b1;
    tick();
    tick();
    I_Ld_BTk.n = 1'b0;
    wait_boot_done("boot_nack", 10);

    // reset during program word 3, then boot again
    do_reset();
    boot_push();
    vcyc = 0;
    pulse_boot();
    repeat (6) tick();
    reset = 1'b0;
    void'(exp_q.pop_back());
    tick();
    reset = 1'b1;
    @(negedge clock);
    chk("abort_busy", W'(O_Busy), '0);
    chk("abort_ld_ftk", O_Ld_FTk, '0);
    chk("abort_mem_en", W'(O_Mem_En), '0);
    chk("abort_queue", W'(exp_q.size()), '0);
    tick();
    tick();
    boot_push();
    vcyc = 0;
    pulse_boot();
    wait_boot_done("reboot", 8);

    // single load, one-cycle latency
    I_Ld_Req = 1'b1; I_Ld_Addr = 32'd7;
    exp_q.push_back(tk(1'b0, 32'hDEAD));
    @(negedge clock);
    chk("ld_gnt", W'(O_Ld_Gnt), W'(1));
    chk("ld_mem_we", W'(O_Mem_We), '0);
    chk("ld_mem_addr", W'(O_Mem_Addr), W'(7));
    tick();
    I_Ld_Req = 1'b0;
    @(negedge clock);
    chk("ld_v_t1", W'(O_Ld_FTk.v), W'(1));
    tick();
    @(negedge clock);
    chk("ld_v_t2", W'(O_Ld_FTk.v), '0);
    tick();

    // address above the SRAM depth wraps onto the low bits
    I_Ld_Req = 1'b1; I_Ld_Addr = 32'h0000_0407;
    exp_q.push_back(tk(1'b0, 32'hDEAD));
    @(negedge clock);
    chk("trunc_mem_addr", W'(O_Mem_Addr), W'(7));
    tick();
    I_Ld_Req = 1'b0;
    tick();

    // load and store to the same address, four cycles
    for (int k = 0; k < 4; k++) begin
      logic ld_win;
      ld_win = (k % 2 == 0);
      I_Ld_Req = 1'b1; I_Ld_Addr = 32'd4;
      I_St_Req = 1'b1; I_St_Addr = 32'd4; I_St_FTk.v = 1'b1; I_St_FTk.d = 32'h55;
      if (ld_win) exp_q.push_back(tk(1'b0, (k == 0) ? 32'd15 : 32'h55));
      @(negedge clock);
      chk("rr_ld_gnt", W'(O_Ld_Gnt), W'(ld_win));
      chk("rr_st_n", W'(O_St_BTk.n), W'(ld_win));
      chk("rr_mem_we", W'(O_Mem_We), W'(!ld_win));
      tick();
    end
    clear_inputs();
    tick();
    tick();

    // load token nacked in RUN: no new load until it is taken
    I_Ld_Req = 1'b1; I_Ld_Addr = 32'd7;
    exp_q.push_back(tk(1'b0, 32'hDEAD));
    tick();
    I_Ld_Addr = 32'd9;
    I_Ld_BTk.n = 1'b1;
    @(negedge clock);
    chk("hold_ld_gnt", W'(O_Ld_Gnt), '0);
    tick();
    I_Ld_BTk.n = 1'b0;
    exp_q.push_back(tk(1'b0, 32'h99));
    @(negedge clock);
    chk("release_ld_gnt", W'(O_Ld_Gnt), W'(1));
    tick();
    clear_inputs();
    tick();

    // store with v=0 writes nothing
    I_St_Req = 1'b1; I_St_Addr = 32'd9; I_St_FTk.v = 1'b0; I_St_FTk.d = 32'h77;
    @(negedge clock);
    chk("stv0_mem_we", W'(O_Mem_We), '0);
    chk("stv0_st_n", W'(O_St_BTk.n), W'(1));
    tick();
    clear_inputs();
    I_Ld_Req = 1'b1; I_Ld_Addr = 32'd9;
    exp_q.push_back(tk(1'b0, 32'h99));
    @(negedge clock);
    chk("stv0_ld_gnt", W'(O_Ld_Gnt), W'(1));
    tick();
    clear_inputs();
    repeat (4) tick();

    chk("final_queue_empty", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
